// File: rtl/conf_pulse_meter_pkg.sv
// conf_pkg: shared types, defaults and helpers for conf_pulse_meter.
// CONF_PEAK_CAPTURE_EN adds a per-record peak-level field.
package conf_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int DROP_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  typedef struct packed {
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] low;
    logic                 sat;
`ifdef CONF_PEAK_CAPTURE_EN
    logic [3:0]           peak;
`endif
  } rec_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/conf_pulse_meter_if.sv
// conf_pulse_meter_if: record readout handshake; peak field exists only with CONF_PEAK_CAPTURE_EN.
interface conf_pulse_meter_if #(parameter int CNT_W = 16);
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] low;
  logic             sat;
`ifdef CONF_PEAK_CAPTURE_EN
  logic [3:0]       peak;
  modport master(output valid, high, low, sat, peak, input ready);
  modport slave(input valid, high, low, sat, peak, output ready);
`else
  modport master(output valid, high, low, sat, input ready);
  modport slave(input valid, high, low, sat, output ready);
`endif
endinterface

// File: rtl/conf_pulse_meter_fifo.sv
// conf_rec_fifo: 2-entry first-word-fall-through record FIFO; push and pop may coincide when full.
module conf_rec_fifo
  import conf_pkg::*;
#(
  parameter type T = rec_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  T mem [2];
  logic wp, rp, do_push, do_pop;
  logic [1:0] cnt;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? T'('0) : mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
    if (reset) begin
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      wp <= wp ^ do_push;
      rp <= rp ^ do_pop;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/conf_pulse_meter.sv
// conf_pulse_meter: measures high/low durations of each confidence-bit cycle into a 2-deep record FIFO.
// Optional per-record peak level capture with CONF_PEAK_CAPTURE_EN.
module conf_pulse_meter
  import conf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              conf_in,
  input  logic [3:0]        level_in,
  conf_pulse_meter_if.master out,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef struct packed {
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] low;
    logic             sat;
`ifdef CONF_PEAK_CAPTURE_EN
    logic [3:0]       peak;
`endif
  } rec_w_t;
  state_t state, state_nx;
  logic conf_q, conf_qq, rise, fall, sat, sat_nx, push, full, empty;
  logic [CNT_W-1:0] high_cnt, low_cnt, high_nx, low_nx, high_inc, low_inc;
  rec_w_t rec, head;
`ifdef CONF_PEAK_CAPTURE_EN
  logic [3:0] peak, peak_nx;
`else
  logic unused_level;
  assign unused_level = ^level_in;
`endif
  assign rise = conf_q && !conf_qq;
  assign fall = !conf_q && conf_qq;
  assign high_inc = CNT_W'(sat_inc(32'(high_cnt), 32'(CMAX)));
  assign low_inc = CNT_W'(sat_inc(32'(low_cnt), 32'(CMAX)));
  always_comb begin
    state_nx = state;
    high_nx = high_cnt;
    low_nx = low_cnt;
    sat_nx = sat;
    push = 1'b0;
`ifdef CONF_PEAK_CAPTURE_EN
    peak_nx = peak;
`endif
    if (!enable) begin
      state_nx = IDLE;
      high_nx = '0;
      low_nx = '0;
      sat_nx = 1'b0;
`ifdef CONF_PEAK_CAPTURE_EN
      peak_nx = '0;
`endif
    end else if (rise && state != HIGH) begin
      // a rise out of LOW closes a full cycle; out of IDLE it only opens one
      push = state == LOW;
      state_nx = HIGH;
      high_nx = CNT_W'(1);
      low_nx = '0;
      sat_nx = 1'b0;
`ifdef CONF_PEAK_CAPTURE_EN
      peak_nx = level_in;
`endif
    end else if (state == HIGH && fall) begin
      state_nx = LOW;
      low_nx = CNT_W'(1);
    end else if (state == HIGH) begin
      high_nx = high_inc;
      sat_nx = sat || high_inc == CMAX;
`ifdef CONF_PEAK_CAPTURE_EN
      peak_nx = level_in > peak ? level_in : peak;
`endif
    end else if (state == LOW) begin
      low_nx = low_inc;
      sat_nx = sat || low_inc == CMAX;
    end
  end
  always_comb begin
    rec.high = high_cnt;
    rec.low = low_cnt;
    rec.sat = sat;
`ifdef CONF_PEAK_CAPTURE_EN
    rec.peak = peak;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      conf_q <= 1'b0;
      conf_qq <= 1'b0;
      high_cnt <= '0;
      low_cnt <= '0;
      sat <= 1'b0;
      drop_cnt <= '0;
`ifdef CONF_PEAK_CAPTURE_EN
      peak <= '0;
`endif
    end else begin
      state <= state_nx;
      conf_q <= conf_in;
      conf_qq <= conf_q;
      high_cnt <= high_nx;
      low_cnt <= low_nx;
      sat <= sat_nx;
`ifdef CONF_PEAK_CAPTURE_EN
      peak <= peak_nx;
`endif
      if (push && full && !out.ready && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
  conf_rec_fifo #(.T(rec_w_t)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(rec),
    .pop(out.ready),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign out.valid = !empty;
  assign out.high = head.high;
  assign out.low = head.low;
  assign out.sat = head.sat;
`ifdef CONF_PEAK_CAPTURE_EN
  assign out.peak = head.peak;
`endif
endmodule

// File: tb/tb_conf_pulse_meter.sv
// tb_conf_pulse_meter: directed and random stimulus against a run-length record model.
module tb_conf_pulse_meter;
  localparam int CW = 4;
  localparam int DW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, conf_in = 1'b0;
  logic [3:0] level_in = 4'd0;
  logic [DW-1:0] drop_cnt;
  conf_pulse_meter_if #(.CNT_W(CW)) ifc ();
  conf_pulse_meter #(.CNT_W(CW), .DROP_W(DW)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .conf_in(conf_in),
    .level_in(level_in),
    .out(ifc),
    .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {int h; int l; bit s;} mrec_t;
  mrec_t q[$];
  mrec_t pend_rec;
  bit pend, started, prev;
  int run, hi_len, drops;
  int total = 0, bad = 0;
  function automatic int clip(int x);
    return x > MAXC ? MAXC : x;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    q.delete();
    pend = 0; prev = 0; run = 0; hi_len = 0; started = 0; drops = 0;
  endtask
  task automatic do_reset();
    reset = 1'b1; conf_in = 1'b0; ifc.ready = 1'b0; level_in = 4'd0;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_valid", ifc.valid, 0);
    chk("rst_high", ifc.high, 0);
    chk("rst_low", ifc.low, 0);
    chk("rst_sat", ifc.sat, 0);
    chk("rst_drop", drop_cnt, 0);
`ifdef CONF_PEAK_CAPTURE_EN
    chk("rst_peak", ifc.peak, 0);
`endif
    reset = 1'b0;
  endtask
  // One clock: the record finished at the previous edge lands in the model FIFO now.
  task automatic step(input logic c, input logic r, input logic [3:0] lv);
    bit popped;
    conf_in = c; ifc.ready = r; level_in = lv;
    @(posedge clk);
    popped = q.size() > 0 && r;
    if (popped) void'(q.pop_front());
    if (pend) begin
      if (q.size() < 2) q.push_back(pend_rec);
      else if (drops < (1 << DW) - 1) drops++;
    end
    pend = 0;
    if (!enable) begin
      started = 0; hi_len = 0; run = 0;
    end else if (c && !prev) begin
      if (hi_len > 0) begin
        pend = 1;
        pend_rec = '{clip(hi_len), clip(run), hi_len >= MAXC || run >= MAXC};
      end
      hi_len = 0; started = 1; run = 1;
    end else if (!c && prev) begin
      hi_len = started ? run : 0;
      run = 1;
    end else run++;
    prev = c;
    #1;
    chk("valid", ifc.valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("high", ifc.high, q[0].h);
      chk("low", ifc.low, q[0].l);
      chk("sat", ifc.sat, q[0].s);
    end
    chk("drop", drop_cnt, drops);
  endtask
  // rmode: 0/1 fixed ready, 2 random ready, 3 ready only on a push edge
  task automatic phase(input logic c, input int n, input int rmode);
    for (int i = 0; i < n; i++)
      step(c, rmode == 2 ? 1'($urandom_range(0, 1)) : rmode == 3 ? pend : 1'(rmode), 4'd0);
  endtask
  initial begin
    model_clear();
    do_reset();
    do_reset();
    // basic record
    phase(0, 4, 1); phase(1, 5, 1); phase(0, 3, 1);
    step(1, 0, 4'd0);
    chk("basic_lat0", ifc.valid, 0);
    step(1, 0, 4'd0);
    chk("basic_valid", ifc.valid, 1);
    chk("basic_high", ifc.high, 5);
    chk("basic_low", ifc.low, 3);
    chk("basic_sat", ifc.sat, 0);
    phase(1, 2, 1);
    // saturation
    do_reset();
    phase(0, 2, 1); phase(1, 20, 1); phase(0, 2, 1);
    step(1, 0, 4'd0); step(1, 0, 4'd0);
    chk("sat_high", ifc.high, 15);
    chk("sat_low", ifc.low, 2);
    chk("sat_flag", ifc.sat, 1);
    phase(1, 2, 1);
    // overflow
    do_reset();
    phase(0, 2, 0);
    for (int i = 0; i < 4; i++) begin
      phase(1, 2 + i, 0); phase(0, 3, 0);
    end
    phase(1, 2, 0);
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head1", ifc.high, 2);
    step(1, 1, 4'd0);
    chk("ovf_head2", ifc.high, 3);
    step(1, 1, 4'd0);
    chk("ovf_empty", ifc.valid, 0);
    // full with simultaneous push and pop
    do_reset();
    phase(0, 2, 0); phase(1, 2, 0); phase(0, 2, 0); phase(1, 3, 0); phase(0, 2, 0); phase(1, 4, 0);
    phase(0, 2, 0); phase(1, 3, 3);
    chk("pp_drop", drop_cnt, 0);
    chk("pp_head", ifc.high, 3);
    step(1, 1, 4'd0);
    chk("pp_next_high", ifc.high, 4);
    chk("pp_next_low", ifc.low, 2);
    phase(1, 2, 1);
    // enable abort mid-LOW
    do_reset();
    phase(0, 2, 1); phase(1, 3, 1); phase(0, 2, 1);
    enable = 1'b0;
    phase(0, 3, 1);
    enable = 1'b1;
    phase(0, 3, 1); phase(1, 2, 1);
    chk("en_norec", ifc.valid, 0);
    phase(0, 4, 1);
    step(1, 0, 4'd0); step(1, 0, 4'd0);
    chk("en_high", ifc.high, 2);
    chk("en_low", ifc.low, 4);
    chk("en_drop", drop_cnt, 0);
    phase(1, 2, 1);
`ifdef CONF_PEAK_CAPTURE_EN
    do_reset();
    phase(0, 2, 1);
    step(1, 1, 4'd0); step(1, 1, 4'd9); step(1, 1, 4'd13); step(1, 1, 4'd11); step(1, 1, 4'd0);
    phase(0, 2, 1);
    step(1, 0, 4'd0); step(1, 0, 4'd0);
    chk("peak", ifc.peak, 13);
    phase(1, 2, 1);
`endif
    // random
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int m;
      m = $urandom_range(0, 3) == 0 ? 0 : 2;
      phase(1, $urandom_range(1, 18), m);
      phase(0, $urandom_range(1, 18), m);
    end
    // reset mid-HIGH with FIFO occupied
    phase(0, 2, 0); phase(1, 2, 0); phase(0, 2, 0); phase(1, 2, 0); phase(0, 2, 0); phase(1, 3, 0);
    chk("pre_rst_valid", ifc.valid, 1);
    do_reset();
    phase(0, 2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
